kb_ascii_ctrl: RTL and testbench

KB_ASCII_CTRL -- requirements
Module: kb_ascii_ctrl

---
 rtl/kb_ascii_ctrl_pkg.sv | 22 ++
 rtl/kb_ascii_ctrl_key2ascii.sv | 70 +++++++
 rtl/kb_ascii_ctrl.sv | 145 ++++++++++++++
 tb/tb_kb_ascii_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/kb_ascii_ctrl_pkg.sv
// Shared PS/2 keyboard constants, FSM state encoding and default FIFO sizing
// for the scan-code to ASCII controller.
package kb_ascii_ctrl_pkg;

   localparam logic [7:0] BRK_CODE = 8'hF0;
   localparam logic [7:0] EXT_CODE = 8'hE0;
   localparam logic [7:0] LSHIFT   = 8'h12;
   localparam logic [7:0] RSHIFT   = 8'h59;
   localparam logic [7:0] CAPS     = 8'h58;

   localparam logic [7:0] UNKNOWN_CHAR = 8'h2A;

   localparam int DEF_W_SIZE = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BRK     = 2'd1,
      EXT     = 2'd2,
      EXT_BRK = 2'd3
   } kb_state_t;

endpackage

// File: rtl/kb_ascii_ctrl_key2ascii.sv
// Combinational PS/2 set-2 scan code to ASCII table. Letters come out upper
// case; case folding is applied by the controller.
module kb_ascii_ctrl_key2ascii
   import kb_ascii_ctrl_pkg::*;
(
   input  logic [7:0] key_code,
   output logic [7:0] ascii_code
);

   always_comb begin
      ascii_code = UNKNOWN_CHAR;
      case (key_code)
         8'h45: ascii_code = 8'h30;
         8'h16: ascii_code = 8'h31;
         8'h1E: ascii_code = 8'h32;
         8'h26: ascii_code = 8'h33;
         8'h25: ascii_code = 8'h34;
         8'h2E: ascii_code = 8'h35;
         8'h36: ascii_code = 8'h36;
         8'h3D: ascii_code = 8'h37;
         8'h3E: ascii_code = 8'h38;
         8'h46: ascii_code = 8'h39;

         8'h1C: ascii_code = 8'h41;
         8'h32: ascii_code = 8'h42;
         8'h21: ascii_code = 8'h43;
         8'h23: ascii_code = 8'h44;
         8'h24: ascii_code = 8'h45;
         8'h2B: ascii_code = 8'h46;
         8'h34: ascii_code = 8'h47;
         8'h33: ascii_code = 8'h48;
         8'h43: ascii_code = 8'h49;
         8'h3B: ascii_code = 8'h4A;
         8'h42: ascii_code = 8'h4B;
         8'h4B: ascii_code = 8'h4C;
         8'h3A: ascii_code = 8'h4D;
         8'h31: ascii_code = 8'h4E;
         8'h44: ascii_code = 8'h4F;
         8'h4D: ascii_code = 8'h50;
         8'h15: ascii_code = 8'h51;
         8'h2D: ascii_code = 8'h52;
         8'h1B: ascii_code = 8'h53;
         8'h2C: ascii_code = 8'h54;
         8'h3C: ascii_code = 8'h55;
         8'h2A: ascii_code = 8'h56;
         8'h1D: ascii_code = 8'h57;
         8'h22: ascii_code = 8'h58;
         8'h35: ascii_code = 8'h59;
         8'h1A: ascii_code = 8'h5A;

         // Punctuation and control keys, unshifted meaning only
         8'h0E: ascii_code = 8'h60;
         8'h4E: ascii_code = 8'h2D;
         8'h55: ascii_code = 8'h3D;
         8'h54: ascii_code = 8'h5B;
         8'h5B: ascii_code = 8'h5D;
         8'h5D: ascii_code = 8'h5C;
         8'h4C: ascii_code = 8'h3B;
         8'h52: ascii_code = 8'h27;
         8'h41: ascii_code = 8'h2C;
         8'h49: ascii_code = 8'h2E;
         8'h4A: ascii_code = 8'h2F;
         8'h29: ascii_code = 8'h20;
         8'h5A: ascii_code = 8'h0D;
         8'h66: ascii_code = 8'h08;
         default: ascii_code = UNKNOWN_CHAR;
      endcase
   end

endmodule

// File: rtl/kb_ascii_ctrl.sv
// PS/2 scan-code decoder: tracks break/extended prefixes, shift and caps-lock,
// translates make codes to ASCII and queues them in a small register-file FIFO.
module kb_ascii_ctrl
   import kb_ascii_ctrl_pkg::*;
#(
   parameter int W_SIZE = DEF_W_SIZE
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_done_tick,
   input  logic [7:0] rx_data,
   input  logic       rd_ascii,
   output logic [7:0] ascii_data,
   output logic       ascii_empty,
   output logic       ascii_full,
   output logic       caps_led,
   output logic       overflow_tick
);

   localparam int              DEPTH   = 2**W_SIZE;
   localparam logic [W_SIZE-1:0] PTR_ONE = {{(W_SIZE-1){1'b0}}, 1'b1};

   kb_state_t         state;
   logic              lshift;
   logic              rshift;
   logic              caps;

   logic [7:0]        key_ascii;
   logic [7:0]        char_in;
   logic              enq;

   logic [7:0]        mem [DEPTH];
   logic [W_SIZE-1:0] wr_ptr;
   logic [W_SIZE-1:0] rd_ptr;
   logic              empty_reg;
   logic              full_reg;
   logic              ovf_reg;
   logic              wr_en;
   logic              rd_en;

   function automatic logic [7:0] apply_case(input logic [7:0] c, input logic upper);
      if ((c >= 8'h41) && (c <= 8'h5A) && !upper)
         return c | 8'h20;
      return c;
   endfunction

   kb_ascii_ctrl_key2ascii key2ascii_unit (
      .key_code   (rx_data),
      .ascii_code (key_ascii)
   );

   assign char_in = apply_case(key_ascii, (lshift | rshift) ^ caps);

   // Only plain make codes seen from IDLE produce a character
   always_comb begin
      enq = 1'b0;
      if (rx_done_tick && (state == IDLE)) begin
         enq = (rx_data != BRK_CODE) && (rx_data != EXT_CODE) &&
               (rx_data != LSHIFT)   && (rx_data != RSHIFT)   &&
               (rx_data != CAPS);
      end
   end

   // A read frees a slot on the same edge, so a full FIFO still accepts a write then
   assign wr_en = enq && (!full_reg || rd_ascii) && !reset;
   assign rd_en = rd_ascii && !empty_reg && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         lshift <= 1'b0;
         rshift <= 1'b0;
         caps   <= 1'b0;
      end else if (rx_done_tick) begin
         case (state)
            IDLE: begin
               case (rx_data)
                  BRK_CODE: state  <= BRK;
                  EXT_CODE: state  <= EXT;
                  LSHIFT:   lshift <= 1'b1;
                  RSHIFT:   rshift <= 1'b1;
                  CAPS:     caps   <= ~caps;
                  default:  state  <= IDLE;
               endcase
            end
            BRK: begin
               if (rx_data == LSHIFT)
                  lshift <= 1'b0;
               if (rx_data == RSHIFT)
                  rshift <= 1'b0;
               state <= IDLE;
            end
            EXT: begin
               state <= (rx_data == BRK_CODE) ? EXT_BRK : IDLE;
            end
            EXT_BRK: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         empty_reg <= 1'b1;
         full_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         ovf_reg <= enq && full_reg && !rd_ascii;
         if (wr_en)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_en)
            rd_ptr <= rd_ptr + PTR_ONE;
         case ({wr_en, rd_en})
            2'b10: begin
               empty_reg <= 1'b0;
               full_reg  <= ((wr_ptr + PTR_ONE) == rd_ptr);
            end
            2'b01: begin
               full_reg  <= 1'b0;
               empty_reg <= ((rd_ptr + PTR_ONE) == wr_ptr);
            end
            default: begin
               empty_reg <= empty_reg;
               full_reg  <= full_reg;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= char_in;
   end

   assign ascii_data    = mem[rd_ptr];
   assign ascii_empty   = empty_reg;
   assign ascii_full    = full_reg;
   assign caps_led      = caps;
   assign overflow_tick = ovf_reg;

endmodule

// File: tb/tb_kb_ascii_ctrl.sv
// Bench for kb_ascii_ctrl: directed key sequences plus random traffic, scored
// against a keystroke-level model of the keyboard and character queue.
module tb_kb_ascii_ctrl;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx_done_tick;
   logic [7:0] rx_data;
   logic       rd_ascii;
   logic [7:0] ascii_data;
   logic       ascii_empty;
   logic       ascii_full;
   logic       caps_led;
   logic       overflow_tick;

   kb_ascii_ctrl #(.W_SIZE(2)) dut (
      .clk           (clk),
      .reset         (reset),
      .rx_done_tick  (rx_done_tick),
      .rx_data       (rx_data),
      .rd_ascii      (rd_ascii),
      .ascii_data    (ascii_data),
      .ascii_empty   (ascii_empty),
      .ascii_full    (ascii_full),
      .caps_led      (caps_led),
      .overflow_tick (overflow_tick)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] expq[$];
   logic [7:0] xlat [256];
   bit         started = 0;
   bit         exp_ovf = 0;
   bit         m_lsh = 0, m_rsh = 0, m_caps = 0;
   bit         after_f0 = 0, after_e0 = 0, after_e0f0 = 0;

   logic [7:0] letter_sc [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                  8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                  8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
   logic [7:0] digit_sc [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
   logic [7:0] punct_sc [14] = '{8'h0E,8'h4E,8'h55,8'h54,8'h5B,8'h5D,8'h4C,8'h52,8'h41,
                                 8'h49,8'h4A,8'h29,8'h5A,8'h66};
   logic [7:0] punct_ch [14] = '{8'h60,8'h2D,8'h3D,8'h5B,8'h5D,8'h5C,8'h3B,8'h27,8'h2C,
                                 8'h2E,8'h2F,8'h20,8'h0D,8'h08};
   logic [7:0] pool [20] = '{8'h12,8'h59,8'h58,8'hF0,8'hE0,8'h1C,8'h32,8'h1A,8'h2A,8'h45,
                             8'h16,8'h29,8'h5A,8'h07,8'h75,8'h6B,8'h4E,8'h3B,8'hF0,8'h12};

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Keystroke-level model of what the keyboard means, applied after each edge
   task automatic model_update(input bit tick, input logic [7:0] code, input bit rst);
      logic [7:0] ch;
      exp_ovf = 0;
      if (rst) begin
         expq.delete();
         m_lsh = 0; m_rsh = 0; m_caps = 0;
         after_f0 = 0; after_e0 = 0; after_e0f0 = 0;
         return;
      end
      if (!tick) return;
      if (after_f0) begin
         if (code == 8'h12) m_lsh = 0;
         if (code == 8'h59) m_rsh = 0;
         after_f0 = 0;
      end else if (after_e0f0) begin
         after_e0f0 = 0;
      end else if (after_e0) begin
         after_e0 = 0;
         after_e0f0 = (code == 8'hF0);
      end else if (code == 8'hF0) after_f0 = 1;
      else if (code == 8'hE0) after_e0 = 1;
      else if (code == 8'h12) m_lsh = 1;
      else if (code == 8'h59) m_rsh = 1;
      else if (code == 8'h58) m_caps = !m_caps;
      else begin
         ch = xlat[code];
         if (ch >= "A" && ch <= "Z" && !((m_lsh || m_rsh) ^ m_caps))
            ch = ch + 8'd32;
         if (expq.size() >= DEPTH) exp_ovf = 1;
         else expq.push_back(ch);
      end
   endtask

   task automatic step(input bit tick, input logic [7:0] code, input bit rd, input bit rst);
      rx_done_tick = tick;
      rx_data      = code;
      rd_ascii     = rd;
      reset        = rst;
      @(posedge clk);
      #1;
      model_update(tick, code, rst);
      started = 1;
   endtask

   task automatic send(input logic [7:0] code);
      step(1, code, 0, 0);
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 1; i++) step(0, 8'h00, 1, 0);
   endtask

   // Monitor: compares visible outputs against the model and pops on reads
   always @(negedge clk) begin
      if (started) begin
         chk("ascii_empty", {7'd0, ascii_empty}, {7'd0, expq.size() == 0});
         chk("ascii_full", {7'd0, ascii_full}, {7'd0, expq.size() == DEPTH});
         chk("caps_led", {7'd0, caps_led}, {7'd0, m_caps});
         chk("overflow_tick", {7'd0, overflow_tick}, {7'd0, exp_ovf});
         if (expq.size() > 0) begin
            chk("ascii_data", ascii_data, expq[0]);
            if (rd_ascii && !reset) void'(expq.pop_front());
         end
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) xlat[i] = 8'h2A;
      for (int i = 0; i < 26; i++) xlat[letter_sc[i]] = 8'h41 + 8'(i);
      for (int i = 0; i < 10; i++) xlat[digit_sc[i]] = 8'h30 + 8'(i);
      for (int i = 0; i < 14; i++) xlat[punct_sc[i]] = punct_ch[i];

      step(0, 8'h00, 0, 1);
      step(0, 8'h00, 0, 1);
      step(0, 8'h00, 0, 0);

      // Single letter then read
      send(8'h1C); step(0, 8'h00, 0, 0); drain();
      // Shift make/break
      send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C); drain();
      // Caps lock, then shift with caps
      send(8'h58); send(8'hF0); send(8'h58); send(8'h1C); drain();
      send(8'h12); send(8'h1C); drain();
      send(8'hF0); send(8'h12); send(8'h58); step(0, 8'h00, 0, 0);
      // Extended make and break discarded
      send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
      step(0, 8'h00, 0, 0); send(8'h16); drain();
      // Fill, overflow, simultaneous read+write at full
      send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
      step(0, 8'h00, 0, 0);
      step(1, 8'h2B, 1, 0);
      step(0, 8'h00, 0, 0);
      drain();
      // Read and write together while empty
      step(1, 8'h32, 1, 0); drain();
      // Reset abandons pending break prefix
      send(8'hF0); step(0, 8'h00, 0, 1); send(8'h1C); drain();
      // Reset with traffic in flight
      send(8'h1C); send(8'h32); step(1, 8'h21, 1, 1); step(0, 8'h00, 0, 0);

      for (int n = 0; n < 3000; n++) begin
         bit         tk;
         bit         rd;
         bit         rs;
         logic [7:0] cd;
         tk = ($urandom_range(0, 99) < 60);
         rd = ($urandom_range(0, 99) < 30);
         rs = ($urandom_range(0, 299) == 0);
         cd = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                          : pool[$urandom_range(0, 19)];
         step(tk, cd, rd, rs);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
